// File: rtl/ssd_pkg.sv
// -----------------------------------------------------------------------------
// ssd_pkg -- shared constants for the seven-segment scan driver.
//   slot_e      : digit slot index (slot 0 = least-significant nibble)
//   SEG_TABLE   : 16-entry hex -> active-low segment table, bit0=a ... bit6=g
//   SEG_BLANK   : all segments off
//   AN_SLOTn    : active-low one-hot anode pattern for each slot, AN_OFF = dark
//   slot_anode(): slot -> anode pattern lookup
// -----------------------------------------------------------------------------
package ssd_pkg;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_SLOT0 = 4'b0111;
    localparam logic [3:0] AN_SLOT1 = 4'b1011;
    localparam logic [3:0] AN_SLOT2 = 4'b1101;
    localparam logic [3:0] AN_SLOT3 = 4'b1110;

    // Entry [n] holds the pattern for hex digit n; listed F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [3:0] slot_anode(input slot_e slot);
        logic [3:0] anode;
        case (slot)
            SLOT0:   anode = AN_SLOT0;
            SLOT1:   anode = AN_SLOT1;
            SLOT2:   anode = AN_SLOT2;
            SLOT3:   anode = AN_SLOT3;
            default: anode = AN_OFF;
        endcase
        return anode;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// -----------------------------------------------------------------------------
// ssd_scan_driver_if -- data/display bundle of the scan driver.
//   value      : 16-bit hex word to display
//   load       : single-cycle strobe capturing value
//   an         : active-low digit anodes (at most one low)
//   cathodes   : active-low segments, bit0=a ... bit6=g
//   frame_done : one-cycle pulse at each frame boundary
// master = word source / display consumer, slave = the driver itself.
// -----------------------------------------------------------------------------
interface ssd_scan_driver_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  cathodes;
    logic        frame_done;

    modport master (
        output value,
        output load,
        input  an,
        input  cathodes,
        input  frame_done
    );

    modport slave (
        input  value,
        input  load,
        output an,
        output cathodes,
        output frame_done
    );
endinterface

// File: rtl/ssd_decode.sv
// -----------------------------------------------------------------------------
// ssd_decode -- combinational hex nibble to active-low seven-segment decoder.
//   nibble   : 4-bit hex digit
//   segments : active-low segments, bit0=a ... bit6=g
// -----------------------------------------------------------------------------
module ssd_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/ssd_scan_driver.sv
// -----------------------------------------------------------------------------
// ssd_scan_driver -- time-multiplexed 4-digit seven-segment scan driver.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : ssd_scan_driver_if.slave (value, load, an, cathodes, frame_done)
// Parameters:
//   TICK_DIV  : clock cycles per digit slot (>= 4)
//   BLANK_CYC : all-off cycles at the start of each slot (1..TICK_DIV-2)
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN -- when defined, slots
// above the most-significant nonzero nibble stay dark; slot 0 is always lit.
// A new word is held in a pending register and only reaches the displayed
// register at the slot 3 -> slot 0 wrap, so a frame never shows a mix of words.
// -----------------------------------------------------------------------------
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic               clock,
    input  logic               reset,
    ssd_scan_driver_if.slave   bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0] tick_r;
    logic [TICK_W-1:0] tick_next_s;
    slot_e             slot_r;
    slot_e             slot_next_s;
    logic              tick_wrap_s;
    logic              frame_wrap_s;
    logic              blank_s;
    logic              lit_s;
    logic [3:0]        nibble_s;
    logic [6:0]        seg_s;
    logic [15:0]       pending_r;
    logic [15:0]       display_r;
    logic [3:0]        an_r;
    logic [6:0]        cathodes_r;
    logic              frame_done_r;

    // Tick counter and slot index state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_r <= {TICK_W{1'b0}};
            slot_r <= SLOT0;
        end else begin
            tick_r <= tick_next_s;
            slot_r <= slot_next_s;
        end
    end

    // Next tick / next slot; the slot only advances on a tick wrap.
    always_comb begin
        tick_wrap_s  = (tick_r == TICK_W'(TICK_DIV - 1));
        tick_next_s  = tick_r + TICK_W'(1);
        slot_next_s  = slot_r;
        frame_wrap_s = 1'b0;
        if (tick_wrap_s) begin
            tick_next_s = {TICK_W{1'b0}};
            case (slot_r)
                SLOT0:   slot_next_s = SLOT1;
                SLOT1:   slot_next_s = SLOT2;
                SLOT2:   slot_next_s = SLOT3;
                SLOT3: begin
                    slot_next_s  = SLOT0;
                    frame_wrap_s = 1'b1;
                end
                default: slot_next_s = SLOT0;
            endcase
        end else begin
            slot_next_s = slot_r;
        end
    end

    // Nibble of the displayed word belonging to the current slot.
    always_comb begin
        nibble_s = 4'h0;
        case (slot_r)
            SLOT0:   nibble_s = display_r[3:0];
            SLOT1:   nibble_s = display_r[7:4];
            SLOT2:   nibble_s = display_r[11:8];
            SLOT3:   nibble_s = display_r[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    // Anti-ghosting blank window and optional leading-zero suppression.
    always_comb begin
        blank_s = (tick_r < TICK_W'(BLANK_CYC));
        lit_s   = 1'b1;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        case (slot_r)
            SLOT0:   lit_s = 1'b1;
            SLOT1:   lit_s = |display_r[15:4];
            SLOT2:   lit_s = |display_r[15:8];
            SLOT3:   lit_s = |display_r[15:12];
            default: lit_s = 1'b1;
        endcase
`else
        lit_s   = 1'b1;
`endif
    end

    ssd_decode u_decode (
        .nibble   (nibble_s),
        .segments (seg_s)
    );

    // Pending/display word registers; a load on the wrap cycle bypasses pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r <= 16'h0000;
            display_r <= 16'h0000;
        end else begin
            if (bus.load) begin
                pending_r <= bus.value;
            end else begin
                pending_r <= pending_r;
            end
            if (frame_wrap_s) begin
                display_r <= bus.load ? bus.value : pending_r;
            end else begin
                display_r <= display_r;
            end
        end
    end

    // Registered display outputs, one cycle behind the selecting counter state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_r         <= AN_OFF;
            cathodes_r   <= SEG_BLANK;
            frame_done_r <= 1'b0;
        end else begin
            if (blank_s || !lit_s) begin
                an_r       <= AN_OFF;
                cathodes_r <= SEG_BLANK;
            end else begin
                an_r       <= slot_anode(slot_r);
                cathodes_r <= seg_s;
            end
            frame_done_r <= frame_wrap_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.cathodes   = cathodes_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan_driver -- directed self-checking bench for ssd_scan_driver with
// TICK_DIV=4, BLANK_CYC=1 (one frame = 16 cycles). Honours the optional
// SSD_LEADING_ZERO_BLANK_EN macro in its expected values.
// Each frame is captured cycle by cycle as {an, cathodes, frame_done} and
// compared against the pattern expected for the word that frame should show.
// -----------------------------------------------------------------------------
module tb_ssd_scan_driver;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [11:0] obs [16];

    ssd_scan_driver_if bus_if ();

    ssd_scan_driver #(
        .TICK_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
            default: s = 7'bxxxxxxx;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] exp_an(input int slot);
        logic [3:0] a;
        case (slot)
            0: a = 4'b0111;
            1: a = 4'b1011;
            2: a = 4'b1101;
            3: a = 4'b1110;
            default: a = 4'bxxxx;
        endcase
        return a;
    endfunction

    function automatic logic exp_lit(input logic [15:0] shown, input int slot);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        logic [15:0] upper;
        upper = shown >> (slot * 4);
        return (slot == 0) || (upper != 16'h0000);
`else
        return 1'b1;
`endif
    endfunction

    // Expected {an, cathodes, frame_done} for cycle i (0..15) of a frame.
    function automatic logic [11:0] exp_vec(input logic [15:0] shown, input int i);
        int         slot;
        int         tick;
        logic       fd;
        logic [3:0] nib;
        slot = i / 4;
        tick = i % 4;
        fd   = (i == 15);
        nib  = shown[slot*4 +: 4];
        if (tick < 1 || !exp_lit(shown, slot))
            return {4'b1111, 7'b1111111, fd};
        else
            return {exp_an(slot), exp_seg(nib), fd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one frame from a frame boundary, applying up to two loads at frame
    // cycles la/lb (-1 = none), recording the outputs of every cycle.
    task automatic capture_frame(input int la, input logic [15:0] va,
                                 input int lb, input logic [15:0] vb);
        for (int i = 0; i < 16; i++) begin
            if (i == la) begin
                bus_if.value = va;
                bus_if.load  = 1'b1;
            end else if (i == lb) begin
                bus_if.value = vb;
                bus_if.load  = 1'b1;
            end else begin
                bus_if.load  = 1'b0;
            end
            step();
            obs[i] = {bus_if.an, bus_if.cathodes, bus_if.frame_done};
        end
        bus_if.load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus_if.value = 16'h0000;
        bus_if.load  = 1'b0;
        #12;
        checks++;
        if (bus_if.an !== 4'b1111) begin
            errors++;
            $display("FAIL reset_an got %b exp 1111", bus_if.an);
        end
        checks++;
        if (bus_if.cathodes !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_cathodes got %b exp 1111111", bus_if.cathodes);
        end
        checks++;
        if (bus_if.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done got %b exp 0", bus_if.frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture_frame(-1, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h0000, i)) begin
                errors++;
                $display("FAIL first_frame cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h0000, i));
            end
        end
    endtask

    task automatic test_load_before_boundary();
        capture_frame(3, 16'h1234, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h0000, i)) begin
                errors++;
                $display("FAIL pre_1234 cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h0000, i));
            end
        end
        capture_frame(-1, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h1234, i)) begin
                errors++;
                $display("FAIL show_1234 cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h1234, i));
            end
        end
    endtask

    task automatic test_mid_frame_load();
        capture_frame(5, 16'hABCD, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h1234, i)) begin
                errors++;
                $display("FAIL no_tear cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h1234, i));
            end
        end
        capture_frame(-1, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'hABCD, i)) begin
                errors++;
                $display("FAIL show_abcd cyc %0d got %b exp %b", i, obs[i], exp_vec(16'hABCD, i));
            end
        end
    endtask

    task automatic test_boundary_load();
        // 1111 sits in pending; 00F0 arrives on the wrap cycle and must win.
        capture_frame(2, 16'h1111, 15, 16'h00F0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'hABCD, i)) begin
                errors++;
                $display("FAIL pre_00f0 cyc %0d got %b exp %b", i, obs[i], exp_vec(16'hABCD, i));
            end
        end
        capture_frame(-1, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h00F0, i)) begin
                errors++;
                $display("FAIL show_00f0 cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h00F0, i));
            end
        end
    endtask

    task automatic test_last_load_wins();
        capture_frame(4, 16'h1111, 9, 16'h8888);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h00F0, i)) begin
                errors++;
                $display("FAIL pre_8888 cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h00F0, i));
            end
        end
        capture_frame(15, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h8888, i)) begin
                errors++;
                $display("FAIL show_8888 cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h8888, i));
            end
        end
        capture_frame(-1, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h0000, i)) begin
                errors++;
                $display("FAIL show_0000 cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h0000, i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        // Display 1234, pend ABCD, then reset part-way through slot 1.
        capture_frame(15, 16'h1234, -1, 16'h0000);
        bus_if.value = 16'hABCD;
        bus_if.load  = 1'b1;
        step();
        bus_if.load  = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus_if.an !== 4'b1011) begin
            errors++;
            $display("FAIL pre_reset_an got %b exp 1011", bus_if.an);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.an !== 4'b1111) begin
            errors++;
            $display("FAIL mid_reset_an got %b exp 1111", bus_if.an);
        end
        checks++;
        if (bus_if.cathodes !== 7'b1111111) begin
            errors++;
            $display("FAIL mid_reset_cathodes got %b exp 1111111", bus_if.cathodes);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        capture_frame(-1, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h0000, i)) begin
                errors++;
                $display("FAIL after_reset cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h0000, i));
            end
        end
        // The pre-reset pending word must not surface at the next boundary.
        capture_frame(-1, 16'h0000, -1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_vec(16'h0000, i)) begin
                errors++;
                $display("FAIL pending_discard cyc %0d got %b exp %b", i, obs[i], exp_vec(16'h0000, i));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_before_boundary();
        test_mid_frame_load();
        test_boundary_load();
        test_last_load_wins();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clock cycles per digit slot; legal range >= 4.
REQ-002 SHALL have parameter BLANK_CYC, default 2: all-off cycles at the start of each slot (anti-ghosting); legal range 1..TICK_DIV-2.
REQ-003 SHALL have port clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port value  in  16  hex word to display (PC or register low half).
REQ-006 SHALL have port load  in  1  single-cycle strobe capturing value.
REQ-007 SHALL have port an  out  4  digit anodes, active-low, one-hot-zero.
REQ-008 SHALL have port cathodes  out  7  segments, active-low; bit0=a ... bit6=g.
REQ-009 SHALL have port frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-010 SHALL run tick counter 0..TICK_DIV-1, wrapping to 0; each wrap advances slot index 0->1->2->3->0.
REQ-011 SHALL map slot 0 -> an=4'b0111, nibble [3:0]; slot 1 -> 4'b1011, [7:4]; slot 2 -> 4'b1101, [11:8]; slot 3 -> 4'b1110, [15:12].
REQ-012 SHALL drive an=4'b1111 and cathodes=7'b1111111 while tick counter < BLANK_CYC; otherwise the slot's anode and decoded nibble.
REQ-013 SHALL register an and cathodes; both change on the same edge, one cycle after the counter state selecting them.
REQ-014 SHALL capture value into a pending register on load; repeated loads within a frame keep only the last.
REQ-015 SHALL copy pending into the display register only at the frame boundary (slot 3 -> slot 0 wrap); no mid-frame tearing.
REQ-016 SHALL, when load coincides with the frame boundary, copy the new value straight into the display register.
REQ-017 SHALL pulse frame_done for exactly the cycle of the slot 3 -> 0 wrap.
REQ-018 SHALL decode hex with fixed patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110.
REQ-019 SHALL never assert more than one anode low in any cycle.

Reset
REQ-020 SHALL on reset low immediately force an=4'b1111, cathodes=7'b1111111, frame_done=0, counters, slot index, pending and display registers to 0.
REQ-021 SHALL, after reset release, begin at slot 0, tick 0 (blank interval first); reset mid-frame discards the pending value.

Configuration
REQ-022 SHALL honour macro SSD_LEADING_ZERO_BLANK_EN: when defined, slots above the most-significant nonzero nibble keep an=1111 for the whole slot; slot 0 always lit (value 0 shows "0").
REQ-023 SHALL, without SSD_LEADING_ZERO_BLANK_EN, light all four digits every frame.

Structure
REQ-024 SHALL place the 16-entry segment table, anode one-hot constants and blank constant (7'b1111111) in shared package ssd_pkg.
REQ-025 SHALL instantiate one combinational sub-module ssd_decode (4-bit nibble -> 7-bit active-low segments).

Verification (TICK_DIV=4, BLANK_CYC=1)
REQ-026 SHALL check: reset low mid-slot -> an=1111, cathodes=1111111 same cycle; after release first lit slot is 0 after 1 blank cycle.
REQ-027 SHALL check: load value=16'h1234 before boundary -> next frame shows 4,3,2,1 on an 0111,1011,1101,1110 with 1-cycle blanks; frame_done every 16 cycles.
REQ-028 SHALL check: load 16'hABCD during slot 1 -> current frame unchanged, next frame shows D,C,B,A.
REQ-029 SHALL check: load 16'h00F0 in the boundary cycle -> that frame shows 0,F,0,0 (macro off) or 0,F only with slots 2,3 dark (macro on).
REQ-030 SHALL check: value 16'h0000 with macro on -> only an=0111 lit with 7'b1000000; loads 16'h1111 then 16'h8888 in one frame -> 8888 displayed.
